// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the sequencer state encoding and the default watchdog limit.
package uart_tx_arb_pkg;

  // Sequencer states. The 2-bit encoding is fixed so that the state can be
  // probed or logged by other blocks without any translation.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_e;

  // Default number of cycles to wait for tx_done before dropping a frame.
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin selector.
// Searches upward from ptr_i, wrapping at N-1, and returns the first set
// request bit as both an index and a one-hot vector. It has no notion of
// UART framing, so the receive-side dispatcher can use it as well.
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o,
  output logic [N-1:0]  onehot_o
);

  // Adds an offset to the pointer and wraps with an explicit compare, so the
  // wrap stays correct when N is not a power of two.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Walk the candidates in priority order; the first valid one wins.
  always_comb begin
    any_o    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && req_i[wrap_add(ptr_i, k)]) begin
        any_o                         = 1'b1;
        idx_o                         = wrap_add(ptr_i, k);
        onehot_o[wrap_add(ptr_i, k)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter and sequencer that shares one txd frame transmitter
// between NUM_REQ requesters. Each accepted frame is latched, launched with
// a one-cycle frame_en, tracked until a tx_done rising edge, and followed by
// GAP_CYCLES idle clocks before the next grant.
// Optional watchdog: define UART_TX_ARB_TIMEOUT_EN to abandon a frame whose
// tx_done edge does not arrive within TIMEOUT_CYCLES.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int FRAME_WD       = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FRAME_WD-1:0]   req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          frame_en,
  output logic [FRAME_WD-1:0]           data_frame,
  input  logic                          tx_done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          err_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         grant_id_q, grant_id_d;
  logic [FRAME_WD-1:0]   data_frame_q, data_frame_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                  tx_done_q;
  logic                  tx_rise;
  logic                  wd_expire;
  logic [NUM_REQ-1:0]    ready_c;

  logic                  pick_any;
  logic [IW-1:0]         pick_idx;
  logic [NUM_REQ-1:0]    pick_onehot;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .any_o    (pick_any),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  assign tx_rise = tx_done & ~tx_done_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic          err_timeout_q, err_timeout_d;

  assign wd_expire   = (state_q == WAIT_DONE) && (wd_cnt_q == WD_LIMIT);
  assign err_timeout = err_timeout_q;
`else
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next-state logic: grant in IDLE, launch pulse, wait for completion, gap.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    data_frame_d = data_frame_q;
    gap_cnt_d    = gap_cnt_q;
    ready_c      = '0;
    frame_en     = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    wd_cnt_d      = wd_cnt_q;
    err_timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          ready_c      = pick_onehot;
          data_frame_d = req_data[pick_idx*FRAME_WD +: FRAME_WD];
          grant_id_d   = pick_idx;
          rr_ptr_d     = (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        frame_en = 1'b1;
        state_d  = WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end
      WAIT_DONE: begin
        if (tx_rise || wd_expire) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          err_timeout_d = !tx_rise;
`endif
        end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          wd_cnt_d = wd_cnt_q + WW'(1);
`endif
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
        else                 gap_cnt_d = gap_cnt_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      data_frame_q <= '0;
      gap_cnt_q    <= '0;
      tx_done_q    <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      data_frame_q <= data_frame_d;
      gap_cnt_q    <= gap_cnt_d;
      tx_done_q    <= tx_done;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd_cnt_q      <= wd_cnt_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  // The accept pulse is held off while reset is asserted, even though the
  // state register already reads IDLE.
  assign req_ready  = ready_c & {NUM_REQ{rst_n}};
  assign data_frame = data_frame_q;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb (NUM_REQ=4, FRAME_WD=8, GAP_CYCLES=2,
// TIMEOUT_CYCLES=16). Build with UART_TX_ARB_TIMEOUT_EN to cover the watchdog.
// A timeline reference model predicts every output every cycle; a vector
// table and hand-written sequences pin down the corner cases.
module tb_uart_tx_arb;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int GAP = 2;
  localparam int TO  = 16;
  localparam int INF = 32'h3fff_ffff;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           frame_en;
  logic [W-1:0]   data_frame;
  logic           tx_done;
  logic [1:0]     grant_id;
  logic           busy;
  logic           err_timeout;

  uart_tx_arb #(
    .NUM_REQ        (N),
    .FRAME_WD       (W),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .frame_en    (frame_en),
    .data_frame  (data_frame),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] valid;
    logic         txd;
    logic [N-1:0] rdy;
    logic         fe;
    logic         bsy;
    logic [1:0]   id;
    logic [W-1:0] data;
  } vec_t;

  vec_t tbl[24];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [N-1:0] sReady;
  logic         sFe, sBusy, sErr;
  logic [W-1:0] sData;
  logic [1:0]   sId;

  int           mPtr, mId, grantAt, idleAt, toAt;
  logic [W-1:0] mData;
  logic         mPrevTx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic modelReset();
    mPtr = 0; mId = 0; mData = '0; grantAt = -1000; idleAt = cyc; toAt = -1; mPrevTx = 1'b0;
  endtask

  // Timeline model: a grant at cycle g launches at g+1, waits from g+2 for a
  // tx_done rise at t (or a timeout), and is idle again at t+GAP+1.
  task automatic modelStep(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic t);
    logic [N-1:0] eRdy;
    bit           eBusy;
    int           w;
    eBusy = (cyc < idleAt);
    eRdy  = '0;
    w     = -1;
    if (!eBusy && v != '0) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && v[(mPtr + k) % N]) w = (mPtr + k) % N;
      end
      eRdy[w] = 1'b1;
    end
    check("ready", sReady, eRdy);
    check("frame_en", sFe, cyc == grantAt + 1);
    check("busy", sBusy, eBusy);
    check("grant_id", sId, mId);
    check("data_frame", sData, mData);
    check("err_timeout", sErr, TO_EN && (cyc == toAt));
    if (w >= 0) begin
      mData = d[w*W +: W]; mId = w; mPtr = (w + 1) % N; grantAt = cyc; idleAt = INF;
    end else if (eBusy && idleAt == INF && cyc >= grantAt + 2) begin
      if (t && !mPrevTx) idleAt = cyc + GAP + 1;
      else if (TO_EN && cyc == grantAt + 2 + TO - 1) begin
        idleAt = cyc + GAP + 1; toAt = cyc + 1;
      end
    end
    mPrevTx = t;
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic t);
    req_valid = v; req_data = d; tx_done = t;
    #1;
    sReady = req_ready; sFe = frame_en; sBusy = busy; sErr = err_timeout;
    sData = data_frame; sId = grant_id;
    modelStep(v, d, t);
  endtask

  task automatic nextCycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic t);
    applyStimulus(v, d, t);
    nextCycle();
  endtask

  task automatic checkOutput(input vec_t r, input int i);
    string tag;
    tag = $sformatf("vec%0d", i);
    check({tag, "_ready"}, sReady, r.rdy);
    check({tag, "_frame_en"}, sFe, r.fe);
    check({tag, "_busy"}, sBusy, r.bsy);
    check({tag, "_grant_id"}, sId, r.id);
    check({tag, "_data"}, sData, r.data);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_frame_en"}, frame_en, 0);
    check({tag, "_data"}, data_frame, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err_timeout, 0);
  endtask

  function automatic vec_t mk(input logic [N-1:0] v, input logic t, input logic [N-1:0] r,
                              input logic f, input logic b, input logic [1:0] id, input logic [W-1:0] dt);
    vec_t x;
    x.valid = v; x.txd = t; x.rdy = r; x.fe = f; x.bsy = b; x.id = id; x.data = dt;
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N*W-1:0] D4;
    logic [N*W-1:0] TD;
    int lastRise;
    int errAt;
    logic [N-1:0] rv;
    logic rt;

    D4 = {8'h44, 8'h33, 8'h22, 8'h11};
    TD = {8'h44, 8'h2B, 8'h22, 8'h11};

    // single requester, entry-high tx_done, 5-cycle held tx_done, fairness
    tbl[0]  = mk(4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 8'h11);
    tbl[1]  = mk(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 8'h2B);
    tbl[2]  = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h2B);
    tbl[3]  = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h2B);
    tbl[4]  = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h2B);
    tbl[5]  = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h2B);
    tbl[6]  = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h2B);
    tbl[7]  = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h2B);
    tbl[8]  = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h2B);
    tbl[9]  = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h2B);
    tbl[10] = mk(4'b0010, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd2, 8'h2B);
    tbl[11] = mk(4'b1010, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 8'h22);
    tbl[12] = mk(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h22);
    tbl[13] = mk(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h22);
    tbl[14] = mk(4'b1010, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h22);
    tbl[15] = mk(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h22);
    tbl[16] = mk(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h22);
    tbl[17] = mk(4'b1010, 1'b0, 4'b1000, 1'b0, 1'b0, 2'd1, 8'h22);
    tbl[18] = mk(4'b1010, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 8'h44);
    tbl[19] = mk(4'b1010, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h44);
    tbl[20] = mk(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h44);
    tbl[21] = mk(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h44);
    tbl[22] = mk(4'b1010, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd3, 8'h44);
    tbl[23] = mk(4'b1010, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 8'h22);

    // power-on reset, with requests pending to prove req_ready stays low
    rst_n = 1'b0; req_valid = 4'hF; req_data = D4; tx_done = 1'b0;
    @(negedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();

    // all four requesters valid: strict rotation 0,1,2,3,0 with a 2-cycle gap
    lastRise = 0;
    for (int f = 0; f < 5; f++) begin
      applyStimulus(4'hF, D4, 1'b0);
      check("rr_order_ready", sReady, 1 << (f % 4));
      if (f > 0) check("gap_len", cyc - lastRise, GAP + 1);
      nextCycle();
      applyStimulus(4'hF, D4, 1'b0);
      check("rr_order_data", sData, D4[(f % 4)*W +: W]);
      check("rr_order_fe", sFe, 1);
      nextCycle();
      cycle(4'hF, D4, 1'b0);
      cycle(4'hF, D4, 1'b0);
      lastRise = cyc;
      cycle(4'hF, D4, 1'b1);
      for (int g = 0; g < GAP; g++) cycle(4'hF, D4, 1'b0);
    end

    // vector table
    for (int i = 0; i < 24; i++) begin
      applyStimulus(tbl[i].valid, TD, tbl[i].txd);
      checkOutput(tbl[i], i);
      nextCycle();
    end

    // asynchronous reset in WAIT_DONE, held across two clock edges
    applyStimulus(4'b1010, TD, 1'b0);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    modelReset();
    applyStimulus(4'b1010, TD, 1'b0);
    check("post_reset_grant", sReady, 4'b0010);
    nextCycle();

    // no tx_done: watchdog fires 16 cycles after WAIT_DONE entry if built in
    cycle(4'b1000, TD, 1'b0);
    errAt = -1;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(4'b1000, TD, 1'b0);
      if (sErr && errAt < 0) errAt = k;
      nextCycle();
      if (errAt >= 0) break;
    end
    check("timeout_latency", errAt, TO_EN ? TO : -1);
    if (TO_EN) begin
      cycle(4'b1000, TD, 1'b0);
    end else begin
      cycle(4'b1000, TD, 1'b1);
      for (int g = 0; g < GAP; g++) cycle(4'b1000, TD, 1'b0);
    end
    applyStimulus(4'b1000, TD, 1'b0);
    check("next_served", sReady, 4'b1000);
    nextCycle();

    // randomized traffic against the model
    rt = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      rv = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) rt = ~rt;
      cycle(rv, {$urandom, $urandom} , rt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one `txd` UART frame transmitter between NUM_REQ requesters.
- Accepts frames over per-requester valid/ready handshakes.
- For each accepted frame: drives the transmitter's `data_frame` bus, issues a one-cycle `frame_en` pulse, then waits for `tx_done`.
- Enforces a programmable inter-frame idle gap before the next grant.
- Sits between client logic (status reporters, command responders) and the `txd` instance.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- FRAME_WD, 8, frame payload width; must match the `txd` FRAME_WD.
- GAP_CYCLES, 2, idle clocks between `tx_done` and the next grant; 0 is legal.
- TIMEOUT_CYCLES, 4096, watchdog limit while waiting for `tx_done`; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- req_valid  in  NUM_REQ  per-requester frame-available flag
- req_data  in  NUM_REQ*FRAME_WD  packed payloads; requester i occupies bits [i*FRAME_WD +: FRAME_WD]
- req_ready  out  NUM_REQ  one-hot accept pulse; a transfer occurs when valid&ready
- frame_en  out  1  start pulse to `txd`
- data_frame  out  FRAME_WD  payload to `txd`
- tx_done  in  1  completion indication from `txd`
- grant_id  out  $clog2(NUM_REQ)  index of the requester currently being served
- busy  out  1  high in every state except IDLE
- err_timeout  out  1  one-cycle watchdog pulse; tied to 0 when the feature is off

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rr_ptr=0, req_ready=0, frame_en=0, data_frame=0, grant_id=0, busy=0, err_timeout=0, tx_done edge register=0. Reset mid-frame aborts silently; the `txd` receives no further `frame_en`.
- States: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE:
  - If any req_valid is set, pick the winner: the first set bit searching upward from rr_ptr, wrapping from NUM_REQ-1 to 0.
  - Same cycle: req_ready[winner]=1 (combinational, one cycle only).
  - Next edge: data_frame<=req_data[winner], grant_id<=winner, rr_ptr<=(winner+1) mod NUM_REQ, state<=LAUNCH.
  - If no req_valid is set, stay in IDLE.
- LAUNCH: frame_en=1 for exactly this one cycle; next state WAIT_DONE. Grant-to-frame_en latency is 1 clock.
- WAIT_DONE:
  - Detect a rising edge of tx_done (tx_done & ~tx_done_q). A level held high for several cycles counts once.
  - On the edge: state<=GAP, or <=IDLE when GAP_CYCLES==0.
  - A tx_done already high on entry does not count; a rising edge is required.
- GAP: counter loads GAP_CYCLES-1 on entry and decrements; when it reaches 0, go to IDLE. Exactly GAP_CYCLES clocks are spent in GAP.
- data_frame and grant_id hold stable from latch until the next grant; they never change while `txd` is shifting.
- req_ready is never asserted outside IDLE. A requester deasserting valid before it is granted is legal and is simply skipped.
- Simultaneous requests: strict rotation. With all requesters valid, grants go 0,1,2,3,0… No requester waits more than NUM_REQ-1 frames.
- Width rules: rr_ptr and grant_id are $clog2(NUM_REQ) bits. For non-power-of-2 NUM_REQ, pointer wrap is explicit compare-to-(NUM_REQ-1), not natural overflow.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT_DONE and increments each cycle in WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1 without a tx_done edge: err_timeout pulses for 1 cycle, state goes to GAP (normal gap then IDLE), and the frame is dropped.
- Undefined: no counter is present, err_timeout is tied to 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Package uart_tx_arb_pkg: state enum type (IDLE, LAUNCH, WAIT_DONE, GAP), 2-bit encoding; default TIMEOUT constant.
- One sub-module, rr_pick: combinational round-robin select.
  - Inputs: req vector and pointer.
  - Outputs: any-valid flag, winner index, one-hot grant.
  - Reusable by the RX-side dispatcher.

Test Plan:
- Single requester: req_valid=4'b0100, data 8'h2B. Required response: req_ready[2] pulses one cycle; next cycle frame_en=1 with data_frame=8'h2B and grant_id=2; busy high until GAP ends.
- All four requesters valid continuously, distinct data 8'h11/22/33/44. Required response: grant order 0,1,2,3,0; data_frame matches at each frame_en; GAP_CYCLES=2 observed between tx_done and the next req_ready.
- Pointer fairness: requester 1 granted, then requesters 1 and 3 both valid. Required response: requester 3 wins next (rr_ptr=2), then requester 1.
- tx_done held high for 5 cycles, followed by a new request. Required response: exactly one frame completion and a single GAP; tx_done high on WAIT_DONE entry is ignored.
- rst_n dropped for 2 cycles during WAIT_DONE. Required response: all outputs 0 immediately (asynchronous); after release, rr_ptr=0 and the next grant goes to the lowest valid index.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, tx_done never asserted. Required response: err_timeout pulses 16 cycles after WAIT_DONE entry; the arbiter then serves the next requester.
